// File: rtl/riskv_wb_bridge.sv
// riskv_wb_bridge: registered bridge from the rv32i strobe/busy memory port
// to a Wishbone classic master. One access at a time, optional bus-cycle
// timeout, and sticky error capture the core can poll.
module riskv_wb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    // rv32i memory port
    input  logic [ADDR_W-1:0]                  mem_addr,
    input  logic [DATA_W-1:0]                  mem_wdata,
    input  logic [DATA_W/8-1:0]                mem_wmask,
    input  logic                               mem_rstrb,
    input  logic                               mem_wstrb,
    output logic [DATA_W-1:0]                  mem_rdata,
    output logic                               mem_rbusy,
    output logic                               mem_wbusy,
    // error reporting
    output logic                               mem_err,
    output logic [ADDR_W-1:0]                  err_addr,
    output logic                               err_timeout,
    output logic [7:0]                         err_count,
    // Wishbone classic master
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] wb_adr,
    output logic [DATA_W-1:0]                  wb_dat_mosi,
    output logic [DATA_W/8-1:0]                wb_sel,
    output logic                               wb_cyc,
    output logic                               wb_stb,
    output logic                               wb_we,
    input  logic [DATA_W-1:0]                  wb_dat_miso,
    input  logic                               wb_ack,
    input  logic                               wb_err
);

    localparam int SEL_W = DATA_W / 8;
    localparam int OFS   = $clog2(SEL_W);
    // Counter wide enough to hold TIMEOUT; one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TMO_LIMIT = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    cnt_inc;
    logic              timed_out;

    logic              start;
    logic              done_ok;
    logic              done_fail;
    logic              fail_is_timeout;

    assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    // The cycle that brings the count up to TIMEOUT is the last one the bus may stay open.
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == TMO_LIMIT);

    // State register; reset closes any open bus cycle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept a strobe in IDLE, leave BUS on ACK, ERR or timeout (in that priority).
    always_comb begin
        state_next      = state;
        start           = 1'b0;
        done_ok         = 1'b0;
        done_fail       = 1'b0;
        fail_is_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wstrb || mem_rstrb) begin
                    start      = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (wb_ack) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if (wb_err) begin
                    done_fail  = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    done_fail       = 1'b1;
                    fail_is_timeout = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request on acceptance so every Wishbone output is stable from registers; write wins over read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else if (start) begin
            adr_q <= mem_addr;
            we_q  <= mem_wstrb;
            if (mem_wstrb) begin
                dat_q <= mem_wdata;
                sel_q <= mem_wmask;
            end else begin
                sel_q <= '1;
            end
        end
    end

    // Count cycles spent in BUS; cleared whenever the bus is idle or the cycle ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == BUS && state_next == BUS) begin
            cnt <= cnt_inc[CNT_W-1:0];
        end else begin
            cnt <= '0;
        end
    end

    // Read data only changes on a successful read; failed accesses leave the last good value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
        end else if (done_ok && !we_q) begin
            mem_rdata <= wb_dat_miso;
        end
    end

    // Error pulse and the polled error registers all update on the same edge; the count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err     <= 1'b0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            mem_err <= done_fail;
            if (done_fail) begin
                err_addr    <= adr_q;
                err_timeout <= fail_is_timeout;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign wb_cyc      = (state == BUS);
    assign wb_stb      = (state == BUS);
    assign wb_we       = we_q;
    assign wb_adr      = adr_q[ADDR_W-1:OFS];
    assign wb_dat_mosi = dat_q;
    assign wb_sel      = sel_q;

    assign mem_rbusy   = (state == BUS) && !we_q;
    assign mem_wbusy   = (state == BUS) && we_q;

endmodule

// File: tb/tb_riskv_wb_bridge.sv
// tb_riskv_wb_bridge: table-driven and randomized checks of riskv_wb_bridge
// against a transaction-level reference model and a behavioural Wishbone slave.
module tb_riskv_wb_bridge;

    localparam int TMO = 8;

    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_NONE = 2;
    localparam int R_BOTH = 3;

    localparam int K_OK  = 0;
    localparam int K_ERR = 1;
    localparam int K_TMO = 2;

    typedef struct {
        bit          is_write;
        bit          both;
        bit          extra;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          waits;
        int          resp;
        logic [31:0] rdata;
        int          exp_cycles;
        int          exp_kind;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        mem_err;
    logic [31:0] err_addr;
    logic        err_timeout;
    logic [7:0]  err_count;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_mosi;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_dat_miso;
    logic        wb_ack;
    logic        wb_err;

    // Second instance with the timeout disabled, driven only by the final test.
    logic        t0_rstrb;
    logic [31:0] t0_rdata;
    logic        t0_rbusy;
    logic        t0_wbusy;
    logic        t0_err;
    logic [31:0] t0_err_addr;
    logic        t0_err_timeout;
    logic [7:0]  t0_err_count;
    logic [29:0] t0_adr;
    logic [31:0] t0_dat_mosi;
    logic [3:0]  t0_sel;
    logic        t0_cyc;
    logic        t0_stb;
    logic        t0_we;
    logic [31:0] zero32;
    logic [3:0]  zero4;
    logic        zero1;

    int          slv_waits;
    int          slv_resp;
    logic [31:0] slv_rdata;
    int          slv_cnt;
    logic        prev_cyc;
    int          cyc_starts;

    int          n_checks;
    int          n_fail;

    logic [31:0] m_rdata;
    logic [31:0] m_err_addr;
    logic        m_err_tmo;
    int          m_err_count;

    riskv_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy),
        .mem_err(mem_err), .err_addr(err_addr), .err_timeout(err_timeout), .err_count(err_count),
        .wb_adr(wb_adr), .wb_dat_mosi(wb_dat_mosi), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_dat_miso(wb_dat_miso), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    riskv_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_addr(zero32), .mem_wdata(zero32), .mem_wmask(zero4),
        .mem_rstrb(t0_rstrb), .mem_wstrb(zero1),
        .mem_rdata(t0_rdata), .mem_rbusy(t0_rbusy), .mem_wbusy(t0_wbusy),
        .mem_err(t0_err), .err_addr(t0_err_addr), .err_timeout(t0_err_timeout), .err_count(t0_err_count),
        .wb_adr(t0_adr), .wb_dat_mosi(t0_dat_mosi), .wb_sel(t0_sel),
        .wb_cyc(t0_cyc), .wb_stb(t0_stb), .wb_we(t0_we),
        .wb_dat_miso(zero32), .wb_ack(zero1), .wb_err(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave: responds after slv_waits wait states with the configured response.
    assign wb_ack      = wb_cyc && wb_stb && (slv_cnt == slv_waits) && (slv_resp == R_ACK || slv_resp == R_BOTH);
    assign wb_err      = wb_cyc && wb_stb && (slv_cnt == slv_waits) && (slv_resp == R_ERR || slv_resp == R_BOTH);
    assign wb_dat_miso = slv_rdata;

    // Slave wait-state counter, restarted whenever the bus is idle.
    always @(posedge clk) begin
        if (wb_cyc) slv_cnt <= slv_cnt + 1;
        else        slv_cnt <= 0;
    end

    // Count how many Wishbone cycles were opened.
    always @(posedge clk) begin
        prev_cyc <= wb_cyc;
        if (wb_cyc && !prev_cyc) cyc_starts <= cyc_starts + 1;
    end

    // Hard stop in case something hangs outside a bounded loop.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: outcome of one access from the slave's behaviour alone.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        if (v.resp != R_NONE && v.waits < TMO) begin
            r.exp_cycles = v.waits + 1;
            r.exp_kind   = (v.resp == R_ERR) ? K_ERR : K_OK;
        end else begin
            r.exp_cycles = TMO;
            r.exp_kind   = K_TMO;
        end
        return r;
    endfunction

    task automatic modelReset();
        m_rdata     = 32'h0;
        m_err_addr  = 32'h0;
        m_err_tmo   = 1'b0;
        m_err_count = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int  cycles;
        int  starts0;
        bit  err_seen;
        bit  wr;
        cycles   = 0;
        err_seen = 0;
        wr       = v.is_write || v.both;
        slv_waits = v.waits;
        slv_resp  = v.resp;
        slv_rdata = v.rdata;
        starts0   = cyc_starts;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wmask = v.wmask;
        mem_wstrb = wr;
        mem_rstrb = !v.is_write || v.both;
        @(negedge clk);
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        checkOutput("cyc_open", {wb_cyc, wb_stb}, 2'b11);
        checkOutput("wb_adr", wb_adr, v.addr[31:2]);
        checkOutput("wb_sel", wb_sel, wr ? v.wmask : 4'hF);
        checkOutput("wb_we", wb_we, wr);
        if (wr) checkOutput("wb_dat_mosi", wb_dat_mosi, v.wdata);
        while (wb_cyc === 1'b1 && cycles < 64) begin
            checkOutput("busy", {mem_rbusy, mem_wbusy}, wr ? 2'b01 : 2'b10);
            if (mem_err !== 1'b0) err_seen = 1;
            cycles++;
            mem_rstrb = (v.extra && cycles == 2);
            @(negedge clk);
        end
        mem_rstrb = 1'b0;
        checkOutput("cyc_len", cycles, v.exp_cycles);
        checkOutput("err_during_bus", err_seen, 0);
        if (v.exp_kind == K_OK) begin
            if (!wr) m_rdata = v.rdata;
        end else begin
            m_err_addr  = v.addr;
            m_err_tmo   = (v.exp_kind == K_TMO);
            m_err_count = (m_err_count < 255) ? m_err_count + 1 : 255;
        end
        checkOutput("busy_after", {mem_rbusy, mem_wbusy}, 2'b00);
        checkOutput("mem_err", mem_err, v.exp_kind != K_OK);
        checkOutput("mem_rdata", mem_rdata, m_rdata);
        checkOutput("err_addr", err_addr, m_err_addr);
        checkOutput("err_timeout", err_timeout, m_err_tmo);
        checkOutput("err_count", err_count, m_err_count);
        if (v.extra) begin
            repeat (3) @(negedge clk);
            checkOutput("no_second_cycle", wb_cyc, 1'b0);
        end
        checkOutput("cyc_starts", cyc_starts - starts0, 1);
    endtask

    function automatic vec_t mk(input bit w, input bit both, input bit extra, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] m, input int waits, input int resp,
                                input logic [31:0] rd, input int cyc, input int kind);
        vec_t v;
        v.is_write = w; v.both = both; v.extra = extra; v.addr = a; v.wdata = d; v.wmask = m;
        v.waits = waits; v.resp = resp; v.rdata = rd; v.exp_cycles = cyc; v.exp_kind = kind;
        return v;
    endfunction

    initial begin
        vec_t dir[10];
        vec_t v;
        int   hi;
        bit   t0_err_seen;

        n_checks = 0; n_fail = 0; cyc_starts = 0; prev_cyc = 1'b0; slv_cnt = 0;
        slv_waits = 0; slv_resp = R_ACK; slv_rdata = 32'h0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0; mem_rstrb = 1'b0; mem_wstrb = 1'b0;
        t0_rstrb = 1'b0; zero32 = 32'h0; zero4 = 4'h0; zero1 = 1'b0;
        modelReset();

        dir[0] = mk(0, 0, 0, 32'h0000_1004, 32'h0,         4'h0, 0, R_ACK,  32'hDEADBEEF, 1, K_OK);
        dir[1] = mk(1, 0, 0, 32'h8200_3000, 32'h0000_0041, 4'h1, 3, R_ACK,  32'h0,        4, K_OK);
        dir[2] = mk(0, 0, 0, 32'h0000_2000, 32'h0,         4'h0, 0, R_ERR,  32'h12345678, 1, K_ERR);
        dir[3] = mk(0, 0, 0, 32'h0000_3008, 32'h0,         4'h0, 0, R_NONE, 32'h0,        TMO, K_TMO);
        dir[4] = mk(1, 1, 0, 32'h0000_0040, 32'hA5A5A5A5, 4'hF, 1, R_ACK,  32'h55,       2, K_OK);
        dir[5] = mk(1, 0, 1, 32'h0000_0050, 32'h11223344, 4'h6, 3, R_ACK,  32'h0,        4, K_OK);
        dir[6] = mk(0, 0, 0, 32'h0000_1007, 32'h0,         4'h0, 2, R_BOTH, 32'hCAFEF00D, 3, K_OK);
        dir[7] = mk(0, 0, 0, 32'h0000_0060, 32'h0,         4'h0, 7, R_ACK,  32'h01020304, 8, K_OK);
        dir[8] = mk(0, 0, 0, 32'h0000_0064, 32'h0,         4'h0, 8, R_ACK,  32'h99999999, TMO, K_TMO);
        dir[9] = mk(1, 0, 0, 32'h0000_0070, 32'h77777777, 4'hC, 0, R_ERR,  32'h0,        1, K_ERR);

        reset = 1'b1;
        #1;
        checkOutput("reset_bus", {wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_mosi}, 0);
        checkOutput("reset_mem", {mem_rdata, mem_rbusy, mem_wbusy, mem_err}, 0);
        checkOutput("reset_err", {err_addr, err_timeout, err_count}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) applyStimulus(dir[i]);

        $display("[TB] randomized vectors");
        for (int i = 0; i < 60; i++) begin
            v.is_write = $urandom_range(0, 1);
            v.both     = ($urandom_range(0, 3) == 0);
            v.extra    = 1'b0;
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.wmask    = $urandom_range(0, 15);
            v.waits    = $urandom_range(0, 10);
            v.resp     = $urandom_range(0, 3);
            v.rdata    = $urandom;
            v = predict(v);
            applyStimulus(v);
        end

        $display("[TB] error count saturation");
        for (int i = 0; i < 300; i++) begin
            v = mk(0, 0, 0, 32'h0000_2000 + 32'(i * 4), 32'h0, 4'h0, 0, R_ERR, 32'h0, 1, K_ERR);
            applyStimulus(v);
        end
        checkOutput("err_count_sat", err_count, 8'd255);

        $display("[TB] reset during bus cycle");
        slv_waits = 5; slv_resp = R_ACK; slv_rdata = 32'h5A5A5A5A;
        mem_addr = 32'h0000_0100; mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_cyc", wb_cyc, 1'b1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_async_bus", {wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_mosi}, 0);
        checkOutput("rst_async_mem", {mem_rdata, mem_rbusy, mem_wbusy, mem_err}, 0);
        checkOutput("rst_async_err", {err_addr, err_timeout, err_count}, 0);
        modelReset();
        @(negedge clk);
        checkOutput("rst_no_err", mem_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        v = mk(0, 0, 0, 32'h0000_0200, 32'h0, 4'h0, 1, R_ACK, 32'h0BADCAFE, 2, K_OK);
        applyStimulus(v);

        $display("[TB] timeout disabled");
        t0_rstrb = 1'b1;
        @(negedge clk);
        t0_rstrb = 1'b0;
        hi = 0;
        t0_err_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            if (t0_cyc === 1'b1) hi++;
            if (t0_err !== 1'b0) t0_err_seen = 1;
            @(negedge clk);
        end
        checkOutput("t0_cyc_high", hi, 1000);
        checkOutput("t0_no_err", t0_err_seen, 0);
        checkOutput("t0_still_busy", t0_rbusy, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
